// File: rtl/switch_capture_pkg.sv
// Shared constants for the switch capture front end: press FSM encodings,
// default sizing and the reset value of the held display word.
package switch_capture_pkg;

  localparam int DEF_WIDTH           = 10;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_CNT_W           = 20;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HELD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    HELD = ST_HELD
  } press_state_t;

  // Every bit of the held word resets to this level.
  localparam logic VALUE_RST_BIT = 1'b0;

endpackage

// File: rtl/switch_capture_debounce_if.sv
// Board-side bundle of the switch capture stage: raw switch/key inputs, the
// held display word with its load strobe, debounced levels and FSM state.
interface switch_capture_debounce_if #(parameter int WIDTH = 10);

  // No valid/ready pair here: value is always valid, and load_pulse is high
  // for exactly the one cycle in which value first shows a new word.
  logic [WIDTH-1:0] sw_in;
  logic             key_n;
  logic [WIDTH-1:0] value;
  logic             load_pulse;
  logic [WIDTH-1:0] sw_stable;
  logic             key_pressed;
  logic [1:0]       state;

  modport master (
    output sw_in, key_n,
    input  value, load_pulse, sw_stable, key_pressed, state
  );

  modport slave (
    input  sw_in, key_n,
    output value, load_pulse, sw_stable, key_pressed, state
  );

endinterface

// File: rtl/switch_capture_debounce_cell.sv
// Two-flop synchroniser followed by a whole-bus debouncer: one candidate
// register and one saturating counter shared by all W bits.
module debounce_cell #(
  parameter int W      = 1,
  parameter int CYCLES = 4,
  parameter int CNT_W  = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [W-1:0]     sync1;
  logic [W-1:0]     sync2;
  logic [W-1:0]     cand;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + CNT_W'(1);

  // The candidate is accepted on the edge where the count reaches LAST, so
  // the counter clears there and can never run past LAST or wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      cand  <= '0;
      cnt   <= '0;
      q     <= '0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cand != q) begin
        if (cnt_inc == LAST) begin
          q   <= cand;
          cnt <= '0;
        end else begin
          cnt <= cnt_inc;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/switch_capture_debounce.sv
// Debounces the slide switches and KEY, and latches the stable switch word
// into value once per debounced press. SWITCH_CAPTURE_AUTO_LOAD_EN also
// reloads value on every debounced switch change.
module switch_capture_debounce
  import switch_capture_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input logic                     clk,
  input logic                     rst,
  switch_capture_debounce_if.slave bus
);

  logic [WIDTH-1:0] sw_stable;
  logic             key_raw;
  logic             key_pressed;
  logic [WIDTH-1:0] value;
  logic             load_pulse;
  logic             load_en;
  logic             load_req;
  press_state_t     state;
  press_state_t     state_nxt;

  debounce_cell #(.W(WIDTH), .CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_sw_db (
    .clk (clk),
    .rst (rst),
    .d   (bus.sw_in),
    .q   (sw_stable)
  );

  // Inverting ahead of the synchroniser is equivalent to syncing key_n from
  // a reset level of 1 and inverting after it.
  assign key_raw = ~bus.key_n;

  debounce_cell #(.W(1), .CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_key_db (
    .clk (clk),
    .rst (rst),
    .d   (key_raw),
    .q   (key_pressed)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    case (state)
      IDLE: if (key_pressed) state_nxt = LOAD;
      LOAD: begin
        load_en   = 1'b1;
        state_nxt = HELD;
      end
      HELD: if (!key_pressed) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SWITCH_CAPTURE_AUTO_LOAD_EN
  logic [WIDTH-1:0] sw_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sw_prev <= '0;
    else     sw_prev <= sw_stable;
  end

  // A key load and an auto load landing together merge into one strobe.
  assign load_req = load_en | (sw_prev != sw_stable);
`else
  assign load_req = load_en;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value      <= {WIDTH{VALUE_RST_BIT}};
      load_pulse <= 1'b0;
    end else begin
      load_pulse <= load_req;
      if (load_req) value <= sw_stable;
    end
  end

  assign bus.value       = value;
  assign bus.load_pulse  = load_pulse;
  assign bus.sw_stable   = sw_stable;
  assign bus.key_pressed = key_pressed;
  assign bus.state       = state;

endmodule

// File: tb/tb_switch_capture_debounce.sv
// Directed bench for switch_capture_debounce with DEBOUNCE_CYCLES=4 and a
// run-length reference model checked every cycle.
module tb_switch_capture_debounce;
  import switch_capture_pkg::*;

  localparam int W  = 10;
  localparam int DC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  switch_capture_debounce_if #(.WIDTH(W)) bus ();

  switch_capture_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .CNT_W(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;
  int key_hi_cnt = 0;
  logic check_en = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] hist[$];
  logic [W-1:0] last_stable = '0;

  // reference model state
  logic [W-1:0] sw_d1 = '0, sw_d2 = '0, sw_run_val = '0, m_sw_stable = '0, m_value = '0;
  logic [W-1:0] sw_d, old_stable;
  int           sw_run_len = 0;
  logic         key_d1 = 1'b0, key_d2 = 1'b0, key_run_val = 1'b0, m_key = 1'b0;
  logic         key_d, old_key;
  int           key_run_len = 0;
  logic         rise_d1 = 1'b0, rise_d2 = 1'b0, chg_d1 = 1'b0, m_pulse = 1'b0, load_now;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // An input level is accepted once DC consecutive synchronised samples agree;
  // a press or (auto build) a stable-word change schedules one load.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_d1 = '0; sw_d2 = '0; sw_run_val = '0; sw_run_len = 0; m_sw_stable = '0;
      key_d1 = 1'b0; key_d2 = 1'b0; key_run_val = 1'b0; key_run_len = 0; m_key = 1'b0;
      rise_d1 = 1'b0; rise_d2 = 1'b0; chg_d1 = 1'b0; m_pulse = 1'b0; m_value = '0;
      exp_q.delete();
    end else begin
      load_now = rise_d2;
`ifdef SWITCH_CAPTURE_AUTO_LOAD_EN
      load_now = load_now | chg_d1;
`endif
      m_pulse = load_now;
      if (load_now) begin
        m_value = m_sw_stable;
        exp_q.push_back(m_sw_stable);
      end
      old_stable = m_sw_stable;
      old_key    = m_key;

      sw_d = sw_d2; sw_d2 = sw_d1; sw_d1 = bus.sw_in;
      if (sw_d == sw_run_val) sw_run_len++;
      else begin sw_run_val = sw_d; sw_run_len = 1; end
      if (sw_run_len >= DC && sw_run_val != m_sw_stable) m_sw_stable = sw_run_val;

      key_d = key_d2; key_d2 = key_d1; key_d1 = ~bus.key_n;
      if (key_d == key_run_val) key_run_len++;
      else begin key_run_val = key_d; key_run_len = 1; end
      if (key_run_len >= DC && key_run_val != m_key) m_key = key_run_val;

      rise_d2 = rise_d1;
      rise_d1 = m_key && !old_key;
      chg_d1  = (m_sw_stable != old_stable);
    end
  end

  logic [W-1:0] popped;
  always @(posedge clk) begin
    #1;
    if (check_en && !rst) begin
      check("sw_stable", bus.sw_stable, m_sw_stable);
      check("key_pressed", {9'b0, bus.key_pressed}, {9'b0, m_key});
      check("load_pulse", {9'b0, bus.load_pulse}, {9'b0, m_pulse});
      check("value", bus.value, m_value);
      if (bus.load_pulse) begin
        n_pulses++;
        if (exp_q.size() == 0) begin
          check("unexpected_load", bus.value, ~bus.value);
        end else begin
          popped = exp_q.pop_front();
          check("load_value", bus.value, popped);
        end
      end
      if (bus.key_pressed) key_hi_cnt++;
      if (bus.sw_stable != last_stable) hist.push_back(bus.sw_stable);
    end
    last_stable = bus.sw_stable;
  end

  int p0, k0;

  initial begin
    bus.sw_in = '0;
    bus.key_n = 1'b1;
    rst = 1'b1;
    tick(2);
    check("rst_value", bus.value, 10'h000);
    check("rst_pulse", {9'b0, bus.load_pulse}, 10'h000);
    check("rst_stable", bus.sw_stable, 10'h000);
    check("rst_key", {9'b0, bus.key_pressed}, 10'h000);
    check("rst_state", {8'b0, bus.state}, {8'b0, ST_IDLE});
    rst = 1'b0;
    check_en = 1'b1;
    tick(3);

    // debounce latency: stable exactly 2+4 edges after the change
    bus.sw_in = 10'h2A5;
    tick(5);
    check("db_early", bus.sw_stable, 10'h000);
    tick(1);
    check("db_latency", bus.sw_stable, 10'h2A5);
    check("db_no_load_value", bus.value, 10'h000);
    check("db_no_pulse", W'(n_pulses), 10'd0);
    tick(4);

    // key load: one pulse over press, hold and release
    p0 = n_pulses;
    bus.key_n = 1'b0;
    tick(20);
    check("key_one_pulse", W'(n_pulses - p0), 10'd1);
    check("key_value", bus.value, 10'h2A5);
    check("key_state_held", {8'b0, bus.state}, {8'b0, ST_HELD});
    bus.key_n = 1'b1;
    tick(10);
    check("key_release_pulses", W'(n_pulses - p0), 10'd1);
    check("key_release_state", {8'b0, bus.state}, {8'b0, ST_IDLE});

    // glitch rejection
    p0 = n_pulses; k0 = key_hi_cnt;
    bus.key_n = 1'b0;
    tick(3);
    bus.key_n = 1'b1;
    tick(10);
    check("glitch_key", W'(key_hi_cnt - k0), 10'd0);
    check("glitch_pulses", W'(n_pulses - p0), 10'd0);
    check("glitch_value", bus.value, 10'h2A5);

    // switch bounce then settle
    hist.delete();
    for (int i = 0; i < 10; i++) begin
      bus.sw_in = (i % 2 == 0) ? 10'h001 : 10'h000;
      tick(2);
    end
    bus.sw_in = 10'h3FF;
    tick(7);
    check("bounce_hist_len", W'(hist.size()), 10'd1);
    if (hist.size() > 0) check("bounce_hist_val", hist[0], 10'h3FF);
    check("bounce_stable", bus.sw_stable, 10'h3FF);
`ifdef SWITCH_CAPTURE_AUTO_LOAD_EN
    check("bounce_value", bus.value, 10'h3FF);
`else
    check("bounce_value", bus.value, 10'h2A5);
`endif

    // reset while HELD, key kept down through and after reset
    bus.key_n = 1'b0;
    tick(12);
    check("pre_rst_value", bus.value, 10'h3FF);
    check("pre_rst_state", {8'b0, bus.state}, {8'b0, ST_HELD});
    rst = 1'b1;
    #1;
    check("mid_rst_value", bus.value, 10'h000);
    check("mid_rst_state", {8'b0, bus.state}, {8'b0, ST_IDLE});
    check("mid_rst_stable", bus.sw_stable, 10'h000);
    check("mid_rst_key", {9'b0, bus.key_pressed}, 10'h000);
    tick(2);
    p0 = n_pulses;
    rst = 1'b0;
    tick(12);
`ifdef SWITCH_CAPTURE_AUTO_LOAD_EN
    check("post_rst_pulses", W'(n_pulses - p0), 10'd2);
`else
    check("post_rst_pulses", W'(n_pulses - p0), 10'd1);
`endif
    check("post_rst_value", bus.value, 10'h3FF);
    bus.key_n = 1'b1;
    tick(10);

    // switch change with no key
    p0 = n_pulses;
    bus.sw_in = 10'h155;
    tick(6);
    check("auto_stable", bus.sw_stable, 10'h155);
    check("auto_no_early_pulse", {9'b0, bus.load_pulse}, 10'h000);
    tick(1);
`ifdef SWITCH_CAPTURE_AUTO_LOAD_EN
    check("auto_pulse", {9'b0, bus.load_pulse}, 10'h001);
    check("auto_value", bus.value, 10'h155);
`else
    check("auto_pulse", {9'b0, bus.load_pulse}, 10'h000);
    check("auto_value", bus.value, 10'h3FF);
`endif
    tick(6);
`ifdef SWITCH_CAPTURE_AUTO_LOAD_EN
    check("auto_pulses", W'(n_pulses - p0), 10'd1);
`else
    check("auto_pulses", W'(n_pulses - p0), 10'd0);
`endif

    check("exp_q_drained", W'(exp_q.size()), 10'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
